// File: rtl/sha256_digest_serializer.sv
// SHA-256 digest serializer: captures H0..H7 on load and streams
// them out one word per valid/ready transfer, H0 first.
module sha256_digest_serializer #(
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = 8,
   localparam int IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        load,
   input  logic [WORD_W*NUM_WORDS-1:0] digest_i,
   input  logic                        out_ready,
   output logic                        out_valid,
   output logic [WORD_W-1:0]           out_data,
   output logic [IDX_W-1:0]            out_index,
   output logic                        out_last,
   output logic                        busy,
   output logic                        overrun
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WORDS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t            r_state, w_state_nxt;
   logic [WORD_W-1:0] r_sreg [NUM_WORDS];
   logic [IDX_W-1:0]  r_index, w_index_nxt;
   logic              r_overrun, w_overrun_nxt;
   logic              w_capture, w_shift, w_final;

   always_comb begin
      w_state_nxt   = r_state;
      w_index_nxt   = r_index;
      w_overrun_nxt = 1'b0;
      w_capture     = 1'b0;
      w_shift       = 1'b0;
      w_final       = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (load) begin
               w_capture   = 1'b1;
               w_index_nxt = '0;
               w_state_nxt = SEND;
            end
         end
         SEND: begin
            w_shift = out_ready;
            w_final = out_ready && (r_index == LAST);
            // A load landing on the final transfer chains a new digest
            if (w_final) begin
               w_index_nxt = '0;
               if (load) w_capture = 1'b1;
               else      w_state_nxt = IDLE;
            end else begin
               if (out_ready) w_index_nxt = r_index + 1'b1;
               w_overrun_nxt = load;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= IDLE;
         r_index   <= '0;
         r_overrun <= 1'b0;
         for (int i = 0; i < NUM_WORDS; i++) r_sreg[i] <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_index   <= w_index_nxt;
         r_overrun <= w_overrun_nxt;
         if (w_capture) begin
            for (int i = 0; i < NUM_WORDS; i++)
               r_sreg[i] <= digest_i[(NUM_WORDS-1-i)*WORD_W +: WORD_W];
         end else if (w_shift) begin
            for (int i = 0; i < NUM_WORDS - 1; i++)
               r_sreg[i] <= r_sreg[i+1];
            r_sreg[NUM_WORDS-1] <= '0;
         end
      end
   end

   assign out_valid = (r_state == SEND);
   assign busy      = (r_state == SEND);
   assign out_data  = r_sreg[0];
   assign out_index = r_index;
   assign out_last  = (r_state == SEND) && (r_index == LAST);
   assign overrun   = r_overrun;

endmodule

// File: doc/sha256_digest_serializer.md
Name: sha256_digest_serializer

Overview:
- Read-side counterpart to the core's 32-bit working/hash registers. Captures the final 256-bit digest (H0..H7) in one cycle on a load pulse.
- Streams the digest out as eight 32-bit words, H0 first, over a valid/ready handshake.
- Sits between the SHA-256 core's hash-register bank and the downstream consumer (bus bridge, UART packer, comparator).

Parameters:
- WORD_W, 32, width of one output word in bits.
- NUM_WORDS, 8, number of words per digest. The digest bus is WORD_W*NUM_WORDS bits wide.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST  input  1  synchronous, active-high reset.
- load  input  1  one-cycle pulse from the core: the digest is final.
- digest_i  input  WORD_W*NUM_WORDS  H0 in bits [255:224], down to H7 in bits [31:0].
- out_ready  input  1  consumer can accept a word this cycle.
- out_valid  output  1  out_data holds a valid word.
- out_data  output  WORD_W  current word.
- out_index  output  3  index of the current word, 0..NUM_WORDS-1.
- out_last  output  1  high with out_valid when out_index == NUM_WORDS-1.
- busy  output  1  high while in SEND.
- overrun  output  1  one-cycle pulse: a load was rejected.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high, sampled on the CLK rising edge only.
- Reset values: state=IDLE, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, overrun=0, shift register cleared.
- Storage: a NUM_WORDS x WORD_W shift register.
  - On capture, the top word comes from digest_i[255:224].
  - out_data is always the top word.
  - Each accepted transfer shifts the register up by one word and fills the bottom with zeros.
- Transfer: a transfer occurs when out_valid && out_ready are both high at a rising edge.
- FSM state IDLE:
  - out_valid=0.
  - load=1 → capture digest_i, set out_index=0, go to SEND.
  - out_valid rises the next cycle. Latency load→first valid word is 1 cycle.
- FSM state SEND:
  - out_valid=1, busy=1.
  - On a transfer with out_index < NUM_WORDS-1: shift, out_index+1.
  - On a transfer with out_index == NUM_WORDS-1: go to IDLE, out_valid=0 next cycle, out_data=0.
  - out_ready=0: hold out_data, out_index and out_valid unchanged. No timeout.
- Load during SEND, not on the final transfer:
  - The load is ignored; the stream in progress is not disturbed.
  - overrun=1 for exactly the next cycle.
- Load coincident with the final transfer (out_index==NUM_WORDS-1, out_valid && out_ready, load=1):
  - The load is accepted: capture the new digest, out_index=0, stay in SEND.
  - out_valid stays high with no bubble.
  - overrun stays 0.
- digest_i is sampled only on an accepted load. Later changes to it have no effect on words already captured.
- out_index wraps only through the IDLE/SEND transitions; it never counts past NUM_WORDS-1.
- Reset mid-stream: the next cycle returns to IDLE with all reset values. Remaining words are discarded and no overrun is raised.
- RST and load high in the same cycle: RST wins, nothing is captured.
- Outputs: all outputs are registered. No combinational path from out_ready to out_valid or out_data.

Test Plan:
- Reset, then load with the digest of "abc" (ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad), out_ready=1 → out_valid from cycle +1 for exactly 8 cycles. Words appear in that order with out_index 0..7, and out_last only on f20015ad. busy falls after the 8th word.
- Same load, out_ready toggling 1,0,0,1,... → each word is held stable while out_ready=0. All 8 words are delivered in order with none duplicated or skipped.
- Load during SEND at out_index=3 with a different digest → overrun pulses once. The remaining words 3..7 still come from the original digest.
- Load asserted with the transfer of word 7 → the next cycle shows out_valid=1, out_index=0, out_data = H0 of the new digest, and overrun=0.
- RST asserted at out_index=5 → the next cycle shows out_valid=0, busy=0, out_data=0. A subsequent load streams a fresh digest from index 0.
- digest_i changed every cycle after the load → the streamed words match the value present in the load cycle only.
